// File: rtl/load_store_unit.sv
// RV32I load/store unit: validates a core command, drives the dataMem req/gnt/rvalid
// handshake with aligned address, byte enables and replicated store data, extends loads.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TRANSFER_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lsu_valid_i,
  input  logic                      lsu_we_i,
  input  logic [2:0]                lsu_funct3_i,
  input  logic [31:0]               lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]     lsu_wdata_i,
  output logic                      lsu_busy_o,
  output logic                      lsu_done_o,
  output logic                      lsu_err_o,
  output logic [DATA_WIDTH-1:0]     lsu_rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [TRANSFER_WIDTH-1:0] mem_be_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    cmd_we_q, cmd_we_d;
  logic [2:0]              cmd_funct3_q, cmd_funct3_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    mem_req_q, mem_req_d;

  logic                    cmd_ok;
  logic [DATA_WIDTH-1:0]   lane;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic                    unused_addr_hi;

  // Address bits above the memory range are deliberately dropped.
  assign unused_addr_hi = ^lsu_addr_i[31:ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_we_q     <= 1'b0;
      cmd_funct3_q <= '0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_we_q     <= cmd_we_d;
      cmd_funct3_q <= cmd_funct3_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      mem_req_q    <= mem_req_d;
    end
  end

  always_comb begin
    cmd_ok = 1'b0;
    case (lsu_funct3_i)
      3'b000:         cmd_ok = 1'b1;
      3'b001:         cmd_ok = ~lsu_addr_i[0];
      3'b010:         cmd_ok = (lsu_addr_i[1:0] == 2'b00);
      3'b100, 3'b101: cmd_ok = ~lsu_we_i & ~(lsu_funct3_i[0] & lsu_addr_i[0]);
      default:        cmd_ok = 1'b0;
    endcase
  end

  always_comb begin
    lane = mem_rdata_i >> {cmd_addr_q[1:0], 3'b000};
    case (cmd_funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'b0, lane[7:0]};
      3'b101:  load_ext = {16'b0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cmd_we_d     = cmd_we_q;
    cmd_funct3_d = cmd_funct3_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    rdata_d      = rdata_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_valid_i) begin
          cmd_we_d     = lsu_we_i;
          cmd_funct3_d = lsu_funct3_i;
          cmd_addr_d   = lsu_addr_i[ADDR_WIDTH-1:0];
          cmd_wdata_d  = lsu_wdata_i;
          if (cmd_ok) begin
            state_d = REQ;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) state_d = RESP;
      end
      RESP: begin
        if (!cmd_we_q) begin
          rdata_d = load_ext;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (mem_rvalid_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // req follows the next state so it rises and falls on the transition edges
    mem_req_d = (state_d == REQ);
  end

  always_comb begin
    lsu_busy_o  = (state_q != IDLE);
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (state_q == REQ) begin
      mem_we_o   = cmd_we_q;
      mem_addr_o = {cmd_addr_q[ADDR_WIDTH-1:2], 2'b00};
      case (cmd_funct3_q[1:0])
        2'b00: begin
          mem_be_o    = TRANSFER_WIDTH'(1) << cmd_addr_q[1:0];
          mem_wdata_o = {4{cmd_wdata_q[7:0]}};
        end
        2'b01: begin
          mem_be_o    = TRANSFER_WIDTH'(3) << cmd_addr_q[1:0];
          mem_wdata_o = {2{cmd_wdata_q[15:0]}};
        end
        default: begin
          mem_be_o    = '1;
          mem_wdata_o = cmd_wdata_q;
        end
      endcase
      if (!cmd_we_q) mem_wdata_o = '0;
    end
  end

  assign lsu_done_o  = done_q;
  assign lsu_err_o   = err_q;
  assign lsu_rdata_o = rdata_q;
  assign mem_req_o   = mem_req_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset corner case,
// and random commands against a byte-addressed reference memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid_i, lsu_we_i;
  logic [2:0]  lsu_funct3_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_busy_o, lsu_done_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  load_store_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .TRANSFER_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid_i(lsu_valid_i), .lsu_we_i(lsu_we_i), .lsu_funct3_i(lsu_funct3_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_busy_o(lsu_busy_o), .lsu_done_o(lsu_done_o), .lsu_err_o(lsu_err_o),
    .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_last_rdata = '0;
  logic [31:0] tb_mem [256];      // the memory the DUT talks to
  logic [7:0]  ref_bytes [1024];  // reference model's view of memory

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    int        gnt_dly;
    int        rv_dly;
    bit        err;
    bit [31:0] rdata;
    bit [3:0]  be;
    bit [31:0] mwdata;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_legal(input bit we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input int size);
    logic [3:0] be;
    int off;
    off = int'(a[1:0]);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + size);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int size);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % size) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int     size;
    longint v;
    size = size_of(f3);
    v = 0;
    for (int i = 0; i < size; i++)
      v += longint'(ref_bytes[(int'(a[9:0]) + i) % 1024]) << (8 * i);
    if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
      v -= (longint'(1) << (8 * size));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < size_of(f3); i++)
      ref_bytes[(int'(a[9:0]) + i) % 1024] = wd[8*i +: 8];
  endtask

  task automatic do_cmd(input string tag, input vec_t v);
    logic [9:0]  ea;
    logic [9:0]  cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    ea = v.addr[9:0] & 10'h3FC;
    lsu_valid_i  = 1'b1;
    lsu_we_i     = v.we;
    lsu_funct3_i = v.f3;
    lsu_addr_i   = v.addr;
    lsu_wdata_i  = v.wdata;
    step();
    lsu_valid_i = 1'b0;
    if (v.err) begin
      chk({tag, ".err_done"}, 32'(lsu_done_o), 32'd1);
      chk({tag, ".err_flag"}, 32'(lsu_err_o), 32'd1);
      chk({tag, ".err_busy"}, 32'(lsu_busy_o), 32'd0);
      chk({tag, ".err_req"}, 32'(mem_req_o), 32'd0);
      chk({tag, ".err_rdata"}, lsu_rdata_o, exp_last_rdata);
      return;
    end
    cap_addr = mem_addr_o;
    cap_be = mem_be_o;
    cap_wdata = mem_wdata_o;
    for (int k = 0; k <= v.gnt_dly; k++) begin
      chk($sformatf("%s.req%0d", tag, k), 32'(mem_req_o), 32'd1);
      chk($sformatf("%s.busy%0d", tag, k), 32'(lsu_busy_o), 32'd1);
      chk($sformatf("%s.done%0d", tag, k), 32'(lsu_done_o), 32'd0);
      chk($sformatf("%s.we%0d", tag, k), 32'(mem_we_o), 32'(v.we));
      chk($sformatf("%s.addr%0d", tag, k), 32'(mem_addr_o), 32'(ea));
      chk($sformatf("%s.be%0d", tag, k), 32'(mem_be_o), 32'(v.be));
      if (v.we) chk($sformatf("%s.wdata%0d", tag, k), mem_wdata_o, v.mwdata);
      mem_gnt_i = (k == v.gnt_dly);
      step();
    end
    mem_gnt_i = 1'b0;
    chk({tag, ".resp_req"}, 32'(mem_req_o), 32'd0);
    chk({tag, ".resp_busy"}, 32'(lsu_busy_o), 32'd1);
    chk({tag, ".resp_bus0"}, {mem_wdata_o[31:15], mem_addr_o, mem_be_o, mem_we_o}, 32'd0);
    if (!v.we) begin
      mem_rdata_i = tb_mem[cap_addr[9:2]];
      step();
      mem_rdata_i = $urandom;
      chk({tag, ".done"}, 32'(lsu_done_o), 32'd1);
      chk({tag, ".noerr"}, 32'(lsu_err_o), 32'd0);
      chk({tag, ".idle"}, 32'(lsu_busy_o), 32'd0);
      chk({tag, ".rdata"}, lsu_rdata_o, v.rdata);
      exp_last_rdata = v.rdata;
    end else begin
      for (int k = 0; k < v.rv_dly; k++) begin
        step();
        chk($sformatf("%s.rvwait_busy%0d", tag, k), 32'(lsu_busy_o), 32'd1);
        chk($sformatf("%s.rvwait_done%0d", tag, k), 32'(lsu_done_o), 32'd0);
      end
      mem_rvalid_i = 1'b1;
      for (int b = 0; b < 4; b++)
        if (cap_be[b]) tb_mem[cap_addr[9:2]][8*b +: 8] = cap_wdata[8*b +: 8];
      step();
      mem_rvalid_i = 1'b0;
      chk({tag, ".done"}, 32'(lsu_done_o), 32'd1);
      chk({tag, ".noerr"}, 32'(lsu_err_o), 32'd0);
      chk({tag, ".idle"}, 32'(lsu_busy_o), 32'd0);
      chk({tag, ".st_rdata"}, lsu_rdata_o, exp_last_rdata);
      model_store(v.f3, v.addr, v.wdata);
    end
  endtask

  function automatic vec_t mkv(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                               input bit [31:0] wdata, input int gd, input int rd, input bit err,
                               input bit [31:0] rdata, input bit [3:0] be, input bit [31:0] mwdata);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.gnt_dly = gd; v.rv_dly = rd;
    v.err = err; v.rdata = rdata; v.be = be; v.mwdata = mwdata;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1'b1; lsu_valid_i = 1'b0; lsu_we_i = 1'b0; lsu_funct3_i = '0;
    lsu_addr_i = '0; lsu_wdata_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    for (int i = 0; i < 256; i++) tb_mem[i] = '0;
    for (int i = 0; i < 1024; i++) ref_bytes[i] = '0;
    tb_mem[4] = 32'h8899AABB;
    ref_bytes[16] = 8'hBB; ref_bytes[17] = 8'hAA; ref_bytes[18] = 8'h99; ref_bytes[19] = 8'h88;

    step(); step();
    chk("rst_outs", {lsu_busy_o, lsu_done_o, lsu_err_o, mem_req_o, mem_we_o, mem_be_o}, 32'd0);
    chk("rst_rdata", lsu_rdata_o, 32'd0);
    chk("rst_bus", {mem_wdata_o[31:10], mem_addr_o}, 32'd0);
    rst = 1'b0;

    vecs.push_back(mkv(0, 3'b010, 32'h10, 0, 1, 0, 0, 32'h8899AABB, 4'hF, 0));
    vecs.push_back(mkv(0, 3'b000, 32'h13, 0, 1, 0, 0, 32'hFFFFFF88, 4'h8, 0));
    vecs.push_back(mkv(0, 3'b100, 32'h13, 0, 1, 0, 0, 32'h00000088, 4'h8, 0));
    vecs.push_back(mkv(0, 3'b001, 32'h12, 0, 0, 0, 0, 32'hFFFF8899, 4'hC, 0));
    vecs.push_back(mkv(0, 3'b101, 32'h10, 0, 2, 0, 0, 32'h0000AABB, 4'h3, 0));
    vecs.push_back(mkv(1, 3'b001, 32'h22, 32'h1234ABCD, 1, 3, 0, 0, 4'hC, 32'hABCDABCD));
    vecs.push_back(mkv(0, 3'b010, 32'h20, 0, 0, 0, 0, 32'hABCD0000, 4'hF, 0));
    vecs.push_back(mkv(0, 3'b010, 32'h06, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(1, 3'b011, 32'h40, 32'h55, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(1, 3'b000, 32'h41, 32'h000000EE, 2, 0, 0, 0, 4'h2, 32'hEEEEEEEE));
    vecs.push_back(mkv(0, 3'b000, 32'h41, 0, 0, 0, 0, 32'hFFFFFFEE, 4'h2, 0));
    vecs.push_back(mkv(0, 3'b010, 32'h40, 0, 4, 0, 0, 32'h0000EE00, 4'hF, 0));
    vecs.push_back(mkv(1, 3'b010, 32'h3FC, 32'hDEADBEEF, 0, 0, 0, 0, 4'hF, 32'hDEADBEEF));
    vecs.push_back(mkv(0, 3'b010, 32'hABCD07FC, 0, 1, 0, 0, 32'hDEADBEEF, 4'hF, 0));
    vecs.push_back(mkv(0, 3'b001, 32'h03, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(0, 3'b110, 32'h00, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(1, 3'b100, 32'h10, 32'h77, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(1, 3'b010, 32'h11, 32'h77, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(0, 3'b100, 32'h22, 0, 1, 0, 0, 32'h000000CD, 4'h4, 0));
    for (int i = 0; i < vecs.size(); i++) do_cmd($sformatf("t%0d", i), vecs[i]);

    // reset while a grant is arriving in REQ; later handshakes must be ignored
    lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_funct3_i = 3'b010; lsu_addr_i = 32'h10;
    step();
    lsu_valid_i = 1'b0;
    chk("rr.req", 32'(mem_req_o), 32'd1);
    step();
    rst = 1'b1; mem_gnt_i = 1'b1;
    step();
    chk("rr.outs", {lsu_busy_o, lsu_done_o, lsu_err_o, mem_req_o, mem_we_o, mem_be_o}, 32'd0);
    chk("rr.bus", {mem_wdata_o[31:10], mem_addr_o}, 32'd0);
    chk("rr.rdata", lsu_rdata_o, 32'd0);
    rst = 1'b0;
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    step();
    mem_rvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rr.quiet%0d", k), {29'd0, lsu_busy_o, lsu_done_o, mem_req_o}, 32'd0);
      step();
    end
    exp_last_rdata = '0;

    for (int n = 0; n < 300; n++) begin
      int size;
      v.we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) v.f3 = 3'($urandom_range(0, 7));
      else if (v.we) v.f3 = 3'($urandom_range(0, 2));
      else begin
        int k;
        k = $urandom_range(0, 4);
        v.f3 = 3'((k < 3) ? k : k + 1);
      end
      size = size_of(v.f3);
      v.addr = $urandom_range(0, 127);
      if ($urandom_range(0, 3) != 0 && size <= 4) v.addr = v.addr & ~(32'(size) - 1);
      if ($urandom_range(0, 4) == 0) v.addr = v.addr | ($urandom & 32'hFFFFFC00);
      v.wdata = $urandom;
      v.gnt_dly = $urandom_range(0, 3);
      v.rv_dly = $urandom_range(0, 3);
      v.err = !model_legal(v.we, v.f3) || (int'(v.addr[1:0]) % size != 0);
      v.be = v.err ? 4'h0 : model_be(v.addr, size);
      v.mwdata = v.err ? 32'h0 : model_wdata(v.wdata, size);
      v.rdata = (v.err || v.we) ? 32'h0 : model_load(v.f3, v.addr);
      do_cmd($sformatf("r%0d", n), v);
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk($sformatf("r%0d.gap", n), {30'd0, lsu_busy_o, lsu_done_o}, 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
